// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// Misses fetch a single word over the iREN/iwait handshake, and hit/miss counters saturate.
module icache_dm #(
    parameter int NUM_FRAMES = 16,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    input  logic             flush,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int IDX_W = $clog2(NUM_FRAMES);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t                  state, next_state;
    logic [NUM_FRAMES-1:0]   valid;
    logic [TAG_W-1:0]        tags [NUM_FRAMES];
    logic [31:0]             data [NUM_FRAMES];
    logic [29:0]             miss_word;
    logic [IDX_W-1:0]        req_idx, fill_idx;
    logic [TAG_W-1:0]        req_tag;
    logic                    tag_match, start_miss, fill_done;
    logic                    unused_offset;

    assign req_idx       = imemaddr[IDX_W+1:2];
    assign req_tag       = imemaddr[31:IDX_W+2];
    assign fill_idx      = miss_word[IDX_W-1:0];
    assign tag_match     = valid[req_idx] && (tags[req_idx] == req_tag);
    assign unused_offset = ^imemaddr[1:0];

    // Hit is purely a lookup on the request; memory handshake signals come only from state and the latched miss address.
    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        start_miss = 1'b0;
        fill_done  = 1'b0;
        case (state)
            IDLE: begin
                if (imemREN && !flush) begin
                    if (tag_match) begin
                        ihit     = 1'b1;
                        imemload = data[req_idx];
                    end else begin
                        start_miss = 1'b1;
                        next_state = FETCH;
                    end
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {miss_word, 2'b00};
                if (!iwait) begin
                    fill_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Flush wins over the valid bit set by a completing fill.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (fill_done) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            miss_word <= '0;
        end else if (start_miss) begin
            miss_word <= imemaddr[31:2];
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tags[fill_idx] <= miss_word[29:IDX_W];
            data[fill_idx] <= iload;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit && (hit_count != '1)) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (start_miss && (miss_count != '1)) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: misses, fills, conflicts, flush, reset mid-fetch, and counter saturation.
module tb_icache_dm;

    logic        CLK;
    logic        nRST, imemREN, flush, iwait;
    logic [31:0] imemaddr, iload;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr, hit_count, miss_count;

    logic        nrst2, ren2, flush2, iwait2;
    logic [31:0] addr2, iload2;
    logic        ihit2, iren2;
    logic [31:0] imemload2, iaddr2;
    logic [3:0]  hit_count2, miss_count2;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_hit  = 0;
    int exp_miss = 0;

    icache_dm dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    icache_dm #(.NUM_FRAMES(16), .CNT_W(4)) dut_sat (
        .CLK(CLK), .nRST(nrst2), .imemREN(ren2), .imemaddr(addr2),
        .ihit(ihit2), .imemload(imemload2), .flush(flush2), .iREN(iren2),
        .iaddr(iaddr2), .iwait(iwait2), .iload(iload2),
        .hit_count(hit_count2), .miss_count(miss_count2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete miss: the IDLE lookup cycle, then `waits` busy cycles and the completion cycle.
    task automatic do_miss(input logic [31:0] a, input logic [31:0] d, input int waits);
        imemREN  = 1'b1;
        imemaddr = a;
        iwait    = 1'b1;
        flush    = 1'b0;
        #2;
        chk("miss_ihit", {31'd0, ihit}, 32'd0);
        chk("miss_iREN", {31'd0, iREN}, 32'd0);
        tick();
        exp_miss++;
        chk("miss_count", miss_count, exp_miss);
        for (int i = 0; i <= waits; i++) begin
            iwait = (i < waits);
            iload = d;
            #2;
            chk("fetch_iREN", {31'd0, iREN}, 32'd1);
            chk("fetch_iaddr", iaddr, {a[31:2], 2'b00});
            chk("fetch_ihit", {31'd0, ihit}, 32'd0);
            tick();
        end
        iwait = 1'b1;
        iload = '0;
    endtask

    task automatic hit_check(input logic [31:0] a, input logic [31:0] d);
        imemREN  = 1'b1;
        imemaddr = a;
        #2;
        chk("hit_ihit", {31'd0, ihit}, 32'd1);
        chk("hit_data", imemload, d);
        chk("hit_iREN", {31'd0, iREN}, 32'd0);
        tick();
        exp_hit++;
        chk("hit_count", hit_count, exp_hit);
    endtask

    initial begin
        nRST = 1'b0; imemREN = 1'b1; imemaddr = '0; flush = 1'b0; iwait = 1'b1; iload = '0;
        nrst2 = 1'b0; ren2 = 1'b0; addr2 = '0; flush2 = 1'b0; iwait2 = 1'b1; iload2 = '0;

        $display("[TB] reset state");
        tick(); tick();
        #2;
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_iREN", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        tick();
        nRST = 1'b1;

        $display("[TB] cold miss and hits");
        do_miss(32'h0000_0000, 32'h3C01_0001, 2);
        hit_check(32'h0000_0000, 32'h3C01_0001);
        hit_check(32'h0000_0000, 32'h3C01_0001);

        $display("[TB] conflict on index 0");
        do_miss(32'h0000_0044, 32'h1111_2222, 0);
        do_miss(32'h0000_0040, 32'hDEAD_BEEF, 1);
        hit_check(32'h0000_0040, 32'hDEAD_BEEF);
        do_miss(32'h0000_0000, 32'h3C01_0001, 0);
        hit_check(32'h0000_0000, 32'h3C01_0001);
        hit_check(32'h0000_0044, 32'h1111_2222);

        $display("[TB] fill completes after request moves away");
        imemREN = 1'b1; imemaddr = 32'h0000_0008; iwait = 1'b1;
        #2;
        chk("abort_miss_ihit", {31'd0, ihit}, 32'd0);
        tick();
        exp_miss++;
        imemREN = 1'b0; imemaddr = 32'h0000_000C; iload = 32'hCAFE_0008;
        #2;
        chk("abort_iREN", {31'd0, iREN}, 32'd1);
        chk("abort_iaddr", iaddr, 32'h0000_0008);
        tick();
        iwait = 1'b0;
        #2;
        chk("abort_iaddr_done", iaddr, 32'h0000_0008);
        tick();
        iwait = 1'b1; iload = '0;
        #2;
        chk("abort_idle_iREN", {31'd0, iREN}, 32'd0);
        chk("abort_idle_ihit", {31'd0, ihit}, 32'd0);
        tick();
        hit_check(32'h0000_0008, 32'hCAFE_0008);
        chk("abort_miss_count", miss_count, exp_miss);

        $display("[TB] flush in IDLE");
        imemREN = 1'b1; imemaddr = 32'h0000_0044; flush = 1'b1;
        #2;
        chk("flush_ihit", {31'd0, ihit}, 32'd0);
        tick();
        flush = 1'b0;
        #2;
        chk("flush_no_fetch", {31'd0, iREN}, 32'd0);
        chk("flush_miss_count", miss_count, exp_miss);
        chk("flush_hit_count", hit_count, exp_hit);
        do_miss(32'h0000_0044, 32'h1111_2222, 0);
        hit_check(32'h0000_0044, 32'h1111_2222);

        $display("[TB] flush during fill completion");
        imemREN = 1'b1; imemaddr = 32'h0000_0010; iwait = 1'b1;
        #2;
        tick();
        exp_miss++;
        iwait = 1'b0; iload = 32'h5555_0010; flush = 1'b1;
        #2;
        chk("flushfill_iREN", {31'd0, iREN}, 32'd1);
        tick();
        flush = 1'b0;
        do_miss(32'h0000_0010, 32'h5555_0010, 0);
        hit_check(32'h0000_0010, 32'h5555_0010);

        $display("[TB] reset during FETCH");
        imemREN = 1'b1; imemaddr = 32'h0000_0020; iwait = 1'b1;
        #2;
        tick();
        #2;
        chk("rstfetch_iREN_before", {31'd0, iREN}, 32'd1);
        nRST = 1'b0; iwait = 1'b0; iload = 32'h0BAD_0BAD;
        #1;
        exp_hit = 0; exp_miss = 0;
        chk("rstfetch_iREN", {31'd0, iREN}, 32'd0);
        chk("rstfetch_iaddr", iaddr, 32'd0);
        chk("rstfetch_hit_count", hit_count, 32'd0);
        chk("rstfetch_miss_count", miss_count, 32'd0);
        tick(); tick();
        nRST = 1'b1; iwait = 1'b1;
        do_miss(32'h0000_0008, 32'h0808_0808, 0);
        hit_check(32'h0000_0008, 32'h0808_0808);
        imemREN = 1'b0;

        $display("[TB] hit counter saturation (4-bit)");
        nrst2 = 1'b1; ren2 = 1'b1; addr2 = 32'h0000_0100; iwait2 = 1'b0; iload2 = 32'hABCD_0100;
        #2;
        chk("sat_first_ihit", {31'd0, ihit2}, 32'd0);
        tick();
        #2;
        chk("sat_iREN", {31'd0, iren2}, 32'd1);
        chk("sat_iaddr", iaddr2, 32'h0000_0100);
        tick();
        #2;
        chk("sat_ihit", {31'd0, ihit2}, 32'd1);
        chk("sat_data", imemload2, 32'hABCD_0100);
        repeat (14) tick();
        chk("sat_hit_count_E", {28'd0, hit_count2}, 32'h0000_000E);
        repeat (3) tick();
        chk("sat_hit_count_F", {28'd0, hit_count2}, 32'h0000_000F);
        chk("sat_miss_count", {28'd0, miss_count2}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
